// File: rtl/wb_cmd_master.sv
// wb_cmd_master: valid/ready command stream to single Wishbone B4 pipelined transactions with timeout guard
module wb_cmd_master #(
  parameter int ADDR_W         = 28,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_we,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [31:0]       i_cmd_data,
  input  logic [3:0]        i_cmd_sel,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [31:0]       o_rsp_data,
  output logic              o_rsp_err,
  output logic              o_rsp_timeout,
  output logic              o_wb_cyc,
  output logic              o_wb_stb,
  output logic              o_wb_we,
  output logic [ADDR_W-1:0] o_wb_addr,
  output logic [31:0]       o_wb_data,
  output logic [3:0]        o_wb_sel,
  input  logic              i_wb_stall,
  input  logic              i_wb_ack,
  input  logic              i_wb_err,
  input  logic [31:0]       i_wb_data,
  output logic              o_busy
);
  localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RSP} state_t;
  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic              we_n, rsp_err_n, rsp_tmo_n;
  logic [ADDR_W-1:0] addr_n;
  logic [31:0]       data_n, rsp_data_n;
  logic [3:0]        sel_n;
  logic              done, tmo;
  // Bus strobes derive from state alone so an asynchronous reset drops them at once
  assign o_cmd_ready = state == IDLE;
  assign o_rsp_valid = state == RSP;
  assign o_wb_cyc    = state == REQ || state == WAIT;
  assign o_wb_stb    = state == REQ;
  assign o_busy      = state != IDLE;
  assign done        = i_wb_ack | i_wb_err;
  assign tmo         = TIMEOUT_CYCLES != 0 && cnt == TLAST;
  // Next-state and next-register computation; slave completion beats the terminal count
  always_comb begin
    state_n    = state;
    cnt_n      = o_wb_cyc ? cnt + 1'b1 : '0;
    we_n       = o_wb_we;
    addr_n     = o_wb_addr;
    data_n     = o_wb_data;
    sel_n      = o_wb_sel;
    rsp_data_n = o_rsp_data;
    rsp_err_n  = o_rsp_err;
    rsp_tmo_n  = o_rsp_timeout;
    case (state)
      IDLE: if (i_cmd_valid) begin
        state_n = REQ;
        we_n    = i_cmd_we;
        addr_n  = i_cmd_addr;
        data_n  = i_cmd_data;
        sel_n   = i_cmd_sel;
      end
      REQ, WAIT: if (done) begin
        state_n    = RSP;
        rsp_err_n  = i_wb_err;
        rsp_tmo_n  = 1'b0;
        rsp_data_n = (i_wb_err | o_wb_we) ? '0 : i_wb_data;
      end else if (tmo) begin
        state_n    = RSP;
        rsp_err_n  = 1'b1;
        rsp_tmo_n  = 1'b1;
        rsp_data_n = '0;
      end else if (state == REQ && !i_wb_stall) begin
        state_n = WAIT;
      end
      RSP: if (i_rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // State, captured command and response registers
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state         <= IDLE;
      cnt           <= '0;
      o_wb_we       <= 1'b0;
      o_wb_addr     <= '0;
      o_wb_data     <= '0;
      o_wb_sel      <= '0;
      o_rsp_data    <= '0;
      o_rsp_err     <= 1'b0;
      o_rsp_timeout <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      o_wb_we       <= we_n;
      o_wb_addr     <= addr_n;
      o_wb_data     <= data_n;
      o_wb_sel      <= sel_n;
      o_rsp_data    <= rsp_data_n;
      o_rsp_err     <= rsp_err_n;
      o_rsp_timeout <= rsp_tmo_n;
    end
  end
endmodule
